// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA pixel-fetch stage.
// Holds the 640x480 raster geometry, the 128x96 frame-memory shape,
// the 5x replication factor and the colour/sync encodings used by
// vga_scale_counter and vga_pixel_fetch.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int SCALE    = 5;
  localparam int MEM_W    = 128;
  localparam int MEM_H    = 96;
  localparam int ADDR_W   = 14;
  localparam int RGB_W    = 3;

  // Column index occupies the low address bits, row the high bits.
  localparam int COL_W = $clog2(MEM_W);
  localparam int ROW_W = ADDR_W - COL_W;
  localparam int SUB_W = $clog2(SCALE);

  // Syncs are active-low, so the idle level is high.
  localparam logic SYNC_IDLE = 1'b1;

  typedef logic [RGB_W-1:0] rgb_t;

  // Frame-memory address of a (row, col) source pixel.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/vga_scale_counter.sv
// Sub/main counter pair used to replicate each source pixel SCALE times.
// The sub counter runs 0..SCALE-1; when it wraps the main counter steps.
//   clk, reset : clock and synchronous active-high reset
//   en         : update strobe (pixel tick); nothing changes without it
//   restart    : treat the current count as zero before applying inc
//   clr        : force the count to zero (overrides inc)
//   inc        : advance the sub counter by one position
//   main       : main count (source pixel index)
module vga_scale_counter
  import vga_pkg::*;
#(
  parameter int MAIN_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic              clr,
  input  logic              inc,
  output logic [MAIN_W-1:0] main
);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

  logic [SUB_W-1:0]  sub_r;
  logic [MAIN_W-1:0] main_r;
  logic [SUB_W-1:0]  base_sub_s;
  logic [MAIN_W-1:0] base_main_s;
  logic [SUB_W-1:0]  sub_nxt_s;
  logic [MAIN_W-1:0] main_nxt_s;

  // Next count: a restart makes the step start from zero, so the pixel
  // that triggers it is counted as the first replica of source pixel 0.
  always_comb begin
    if (restart) begin
      base_sub_s  = {SUB_W{1'b0}};
      base_main_s = {MAIN_W{1'b0}};
    end else begin
      base_sub_s  = sub_r;
      base_main_s = main_r;
    end

    if (clr) begin
      sub_nxt_s  = {SUB_W{1'b0}};
      main_nxt_s = {MAIN_W{1'b0}};
    end else if (inc) begin
      if (base_sub_s == SUB_LAST) begin
        sub_nxt_s  = {SUB_W{1'b0}};
        main_nxt_s = base_main_s + MAIN_W'(1);
      end else begin
        sub_nxt_s  = base_sub_s + SUB_W'(1);
        main_nxt_s = base_main_s;
      end
    end else begin
      sub_nxt_s  = base_sub_s;
      main_nxt_s = base_main_s;
    end
  end

  // Count register, updated only on enabled edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_r  <= {SUB_W{1'b0}};
      main_r <= {MAIN_W{1'b0}};
    end else if (en) begin
      sub_r  <= sub_nxt_s;
      main_r <= main_nxt_s;
    end else begin
      sub_r  <= sub_r;
      main_r <= main_r;
    end
  end

  assign main = main_r;

endmodule

// File: rtl/vga_pixel_fetch.sv
// Pixel-data stage in front of the VGA pins. Maps the 640x480 raster onto
// a 128x96 3-bit frame memory with 5x replication, fetches the pixel and
// drives colour plus syncs, all delayed by one pixel so they stay aligned.
//   clk, reset          : 100 MHz clock, synchronous active-high reset
//   pix_tick            : one-clk 25 MHz pixel enable
//   h_cnt, v_cnt        : raster position of the current pixel
//   video_on            : current pixel is inside the visible area
//   hsync_in, vsync_in  : raw syncs for the current pixel
//   mem_addr, mem_rdata : frame-memory read port (1-clk synchronous read)
//   VGA_RED/GREEN/BLUE  : registered colour
//   VGA_HSYNC/VSYNC     : registered syncs, aligned with the colour
module vga_pixel_fetch
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_tick,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [RGB_W-1:0]  mem_rdata,
  output logic              VGA_RED,
  output logic              VGA_GREEN,
  output logic              VGA_BLUE,
  output logic              VGA_HSYNC,
  output logic              VGA_VSYNC
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);

  logic              line_end_s;
  logic              last_line_s;
  logic              resync_s;
  logic              row_inc_s;
  logic              row_clr_s;
  logic [COL_W-1:0]  col_s;
  logic [ROW_W-1:0]  row_s;
  logic [ADDR_W-1:0] fetch_addr_s;
  rgb_t              rgb_nxt_s;

  logic              video_on_d_r;
  logic              hs_d_r;
  logic              vs_d_r;
  rgb_t              rgb_r;
  logic              hsync_r;
  logic              vsync_r;

  // Raster decodes. The (0,0) pixel restarts both counters so a reset
  // released mid-frame is recovered at the next frame start; that pixel
  // itself must fetch address 0.
  always_comb begin
    line_end_s  = video_on && (h_cnt == H_LAST);
    last_line_s = (v_cnt == V_LAST);
    resync_s    = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    row_inc_s   = line_end_s && !last_line_s;
    row_clr_s   = line_end_s && last_line_s;
    if (resync_s) begin
      fetch_addr_s = {ADDR_W{1'b0}};
    end else begin
      fetch_addr_s = pix_addr(row_s, col_s);
    end
  end

  // Column: one replica per visible pixel, cleared at the end of each line.
  vga_scale_counter #(.MAIN_W(COL_W)) u_col_cnt (
    .clk     (clk),
    .reset   (reset),
    .en      (pix_tick),
    .restart (resync_s),
    .clr     (line_end_s),
    .inc     (video_on),
    .main    (col_s)
  );

  // Row: one replica per visible line, cleared after the last visible line.
  vga_scale_counter #(.MAIN_W(ROW_W)) u_row_cnt (
    .clk     (clk),
    .reset   (reset),
    .en      (pix_tick),
    .restart (resync_s),
    .clr     (row_clr_s),
    .inc     (row_inc_s),
    .main    (row_s)
  );

  // Stage A: issue the fetch and delay the per-pixel controls alongside it.
  // The address is held through blanking.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr     <= {ADDR_W{1'b0}};
      video_on_d_r <= 1'b0;
      hs_d_r       <= SYNC_IDLE;
      vs_d_r       <= SYNC_IDLE;
    end else if (pix_tick) begin
      if (video_on) begin
        mem_addr <= fetch_addr_s;
      end else begin
        mem_addr <= mem_addr;
      end
      video_on_d_r <= video_on;
      hs_d_r       <= hsync_in;
      vs_d_r       <= vsync_in;
    end else begin
      mem_addr     <= mem_addr;
      video_on_d_r <= video_on_d_r;
      hs_d_r       <= hs_d_r;
      vs_d_r       <= vs_d_r;
    end
  end

  // Colour for the pixel fetched one tick ago; black outside the visible area.
  always_comb begin
    if (video_on_d_r) begin
      rgb_nxt_s = mem_rdata;
    end else begin
      rgb_nxt_s = {RGB_W{1'b0}};
    end
  end

  // Stage B: colour and syncs leave together, so they cannot skew.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_r   <= {RGB_W{1'b0}};
      hsync_r <= SYNC_IDLE;
      vsync_r <= SYNC_IDLE;
    end else if (pix_tick) begin
      rgb_r   <= rgb_nxt_s;
      hsync_r <= hs_d_r;
      vsync_r <= vs_d_r;
    end else begin
      rgb_r   <= rgb_r;
      hsync_r <= hsync_r;
      vsync_r <= vsync_r;
    end
  end

  assign VGA_RED   = rgb_r[2];
  assign VGA_GREEN = rgb_r[1];
  assign VGA_BLUE  = rgb_r[0];
  assign VGA_HSYNC = hsync_r;
  assign VGA_VSYNC = vsync_r;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch. A reference model predicts,
// from raster position alone, the fetch address {v/5, h/5}, the colour
// mem[{v/5, h/5}] one pixel later, and the syncs one pixel later.
// Lines not driven pixel-by-pixel only get their line-end tick, so the
// model treats their address/colour as unknown but still checks syncs.
module tb_vga_pixel_fetch;
  import vga_pkg::*;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              pix_tick  = 1'b0;
  logic [9:0]        h_cnt     = 10'd0;
  logic [9:0]        v_cnt     = 10'd0;
  logic              video_on  = 1'b0;
  logic              hsync_in  = 1'b1;
  logic              vsync_in  = 1'b1;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_rdata = 3'd0;
  logic              VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC;

  logic [2:0] mem [0:12287];
  bit         full_sel [0:524];

  int checks = 0;
  int errors = 0;

  // Driver-side controls
  bit    model_ok    = 1'b0;
  bit    lit_on      = 1'b0;
  bit    mem_is_addr = 1'b1;
  bit    lit_addr_en = 1'b0;
  bit    lit_rgb_en  = 1'b0;
  int    lit_addr_val = 0;
  int    lit_rgb_val  = 0;
  string lit_name     = "";

  // Inputs as sampled by the DUT at the last rising edge
  bit    s_reset = 1'b0, s_tick = 1'b0, s_video = 1'b0, s_hs = 1'b1, s_vs = 1'b1;
  bit    s_ok = 1'b0, s_la_en = 1'b0, s_lr_en = 1'b0;
  int    s_h = 0, s_v = 0, s_la_val = 0, s_lr_val = 0;
  string s_lname = "";

  // Model state
  bit armed = 1'b0, synced = 1'b0;
  bit rgb_known = 1'b0, addr_known = 1'b0, p_known = 1'b0;
  int exp_rgb = 0, exp_hs = 1, exp_vs = 1, exp_addr = 0;
  int p_rgb = 0, p_hs = 1, p_vs = 1;
  int idx;

  vga_pixel_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .pix_tick  (pix_tick),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .video_on  (video_on),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .VGA_RED   (VGA_RED),
    .VGA_GREEN (VGA_GREEN),
    .VGA_BLUE  (VGA_BLUE),
    .VGA_HSYNC (VGA_HSYNC),
    .VGA_VSYNC (VGA_VSYNC)
  );

  always #5 clk = ~clk;

  // Frame memory with one-clock synchronous read
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  // Capture what the DUT saw on this edge
  always @(posedge clk) begin
    s_reset  <= reset;
    s_tick   <= pix_tick;
    s_h      <= int'(h_cnt);
    s_v      <= int'(v_cnt);
    s_video  <= video_on;
    s_hs     <= hsync_in;
    s_vs     <= vsync_in;
    s_ok     <= model_ok;
    s_la_en  <= lit_addr_en;
    s_lr_en  <= lit_rgb_en;
    s_la_val <= lit_addr_val;
    s_lr_val <= lit_rgb_val;
    s_lname  <= lit_name;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (h=%0d v=%0d t=%0t): got %0d, want %0d", name, s_h, s_v, $time, act, exp);
    end
  endtask

  // Model update and comparison, half a cycle after each edge
  always @(negedge clk) begin
    if (s_reset) begin
      armed = 1'b1; synced = 1'b0;
      exp_rgb = 0; rgb_known = 1'b1; exp_hs = 1; exp_vs = 1;
      exp_addr = 0; addr_known = 1'b1;
      p_rgb = 0; p_known = 1'b1; p_hs = 1; p_vs = 1;
    end else if (s_tick) begin
      exp_rgb = p_rgb; rgb_known = p_known; exp_hs = p_hs; exp_vs = p_vs;
      if (s_h == 0 && s_v == 0) synced = 1'b1;
      if (s_video) begin
        idx = (s_v / 5) * 128 + s_h / 5;
        if (synced && s_ok) begin
          exp_addr = idx; addr_known = 1'b1;
          p_rgb = int'(mem[idx]); p_known = 1'b1;
        end else begin
          addr_known = 1'b0; p_known = 1'b0;
        end
      end else begin
        p_rgb = 0; p_known = 1'b1;
      end
      p_hs = int'(s_hs); p_vs = int'(s_vs);
    end
    if (armed) begin
      chk("hsync", int'(VGA_HSYNC), exp_hs);
      chk("vsync", int'(VGA_VSYNC), exp_vs);
      if (rgb_known)  chk("rgb", int'({VGA_RED, VGA_GREEN, VGA_BLUE}), exp_rgb);
      if (addr_known) chk("mem_addr", int'(mem_addr), exp_addr);
      if (s_la_en)    chk(s_lname, int'(mem_addr), s_la_val);
      if (s_lr_en)    chk(s_lname, int'({VGA_RED, VGA_GREEN, VGA_BLUE}), s_lr_val);
    end
  end

  // One pixel: tick for one clk, then idle for gap-1 clks.
  task automatic px(input int h, input int v, input int gap, input bit rst);
    h_cnt    = 10'(h);
    v_cnt    = 10'(v);
    video_on = (h < 640) && (v < 480);
    hsync_in = !((h >= 656) && (h < 752));
    vsync_in = !((v == 490) || (v == 491));
    pix_tick = 1'b1;
    if (rst) reset = 1'b1;
    lit_addr_en = 1'b0;
    lit_rgb_en  = 1'b0;
    if (lit_on && !reset) begin
      if (v == 0 && (h == 0 || h == 4)) begin
        lit_addr_en = 1'b1; lit_addr_val = 0; lit_name = "addr_first_group";
      end else if (v == 0 && h == 5) begin
        lit_addr_en = 1'b1; lit_addr_val = 1; lit_name = "addr_second_group";
        lit_rgb_en = mem_is_addr; lit_rgb_val = 0;
      end else if (v == 0 && h == 6) begin
        lit_rgb_en = mem_is_addr; lit_rgb_val = 1; lit_name = "rgb_after_step";
      end else if (v == 4 && h == 639) begin
        lit_addr_en = 1'b1; lit_addr_val = 127; lit_name = "addr_line4_end";
      end else if (v == 5 && h == 0) begin
        lit_addr_en = 1'b1; lit_addr_val = 128; lit_name = "addr_line5_start";
      end else if (v == 479 && h == 639) begin
        lit_addr_en = 1'b1; lit_addr_val = 12287; lit_name = "addr_last";
      end else if (v == 479 && h == 640) begin
        lit_rgb_en = mem_is_addr; lit_rgb_val = 7; lit_name = "rgb_last";
      end else if (v < 480 && h == 641) begin
        lit_rgb_en = 1'b1; lit_rgb_val = 0; lit_name = "rgb_blank_start";
      end
    end
    @(posedge clk); #2;
    pix_tick    = 1'b0;
    lit_addr_en = 1'b0;
    lit_rgb_en  = 1'b0;
    if (rst) reset = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #2;
    end
  endtask

  // One frame; full_sel picks the lines driven pixel by pixel.
  task automatic run_frame(input int gap, input bit sweep0, input int rst_v, input int rst_h);
    int blank_set [8] = '{640, 641, 656, 657, 700, 752, 753, 799};
    for (int v = 0; v < 525; v++) begin
      if (v < 480) begin
        model_ok = full_sel[v];
        if (full_sel[v]) begin
          for (int h = 0; h < 640; h++) px(h, v, gap, (v == rst_v) && (h == rst_h));
          if (sweep0 && v == 0) begin
            for (int h = 640; h < 800; h++) px(h, v, gap, 1'b0);
          end else begin
            foreach (blank_set[k]) px(blank_set[k], v, gap, 1'b0);
          end
        end else begin
          px(639, v, gap, 1'b0);
          px(640, v, gap, 1'b0);
        end
      end else begin
        px(0, v, gap, 1'b0);
        px(656, v, gap, 1'b0);
      end
    end
  endtask

  task automatic clear_sel();
    for (int v = 0; v < 525; v++) full_sel[v] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 12288; i++) mem[i] = 3'(i % 8);
    clear_sel();

    // Reset held for 12+ clks with pixel ticks running
    reset = 1'b1;
    @(posedge clk); #2;
    repeat (3) px(600, 10, 4, 1'b0);
    reset = 1'b0;

    // Frame 1: memory holds addr[2:0], 4-clk pixel period, blanking sweep
    lit_on = 1'b1; mem_is_addr = 1'b1;
    full_sel[0] = 1'b1; full_sel[4] = 1'b1; full_sel[5] = 1'b1; full_sel[479] = 1'b1;
    run_frame(4, 1'b1, -1, -1);

    // Frame 2: random memory, reset pulsed at (300,200)
    for (int i = 0; i < 12288; i++) mem[i] = 3'($urandom_range(0, 7));
    lit_on = 1'b0; mem_is_addr = 1'b0;
    clear_sel();
    full_sel[0] = 1'b1; full_sel[199] = 1'b1; full_sel[200] = 1'b1;
    full_sel[201] = 1'b1; full_sel[479] = 1'b1;
    run_frame(2, 1'b0, 200, 300);

    // Frame 3: fresh random memory, must be exact again after resync
    for (int i = 0; i < 12288; i++) mem[i] = 3'($urandom_range(0, 7));
    lit_on = 1'b1;
    clear_sel();
    full_sel[0] = 1'b1; full_sel[1] = 1'b1; full_sel[4] = 1'b1; full_sel[5] = 1'b1;
    full_sel[96] = 1'b1; full_sel[97] = 1'b1; full_sel[250] = 1'b1;
    full_sel[477] = 1'b1; full_sel[478] = 1'b1; full_sel[479] = 1'b1;
    run_frame(3, 1'b0, -1, -1);

    repeat (4) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
